// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and defaults for the forwarding scoreboard.
// Holds the pending-write entry layout and the match helper.
package fwd_scoreboard_pkg;

  localparam int DEPTH_DEF      = 3;
  localparam int DATA_W_DEF     = 32;
  localparam int LOAD_STAGE_DEF = 2;
  localparam int STAGE_W        = 4;
  localparam int DEPTH_MAX      = 1 << STAGE_W;

  typedef logic [4:0]         reg_t;
  typedef logic [STAGE_W-1:0] stage_t;

  localparam reg_t REG_ZERO = 5'd0;

  typedef struct packed {
    logic   valid;
    logic   we;
    reg_t   dest;
    stage_t ready_at;
  } entry_t;

  function automatic logic hits(
    input entry_t e,
    input logic   en,
    input reg_t   r
  );
    return en && (r != REG_ZERO) && e.valid
        && e.we && (e.dest == r);
  endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// ID-stage to scoreboard bundle: decoded sources, pipeline
// results and the forwarded operands / stall handshake.
interface fwd_scoreboard_if
  import fwd_scoreboard_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic                    id_valid;
  reg_t                    id_rs;
  reg_t                    id_rt;
  logic                    id_use_rs;
  logic                    id_use_rt;
  reg_t                    id_dest;
  logic                    id_we;
  logic                    id_load;
  logic                    ext_stall;
  logic                    flush_id;
  logic                    flush_all;
  logic [DATA_W-1:0]       qa;
  logic [DATA_W-1:0]       qb;
  logic [DEPTH*DATA_W-1:0] stage_data;
  logic [DATA_W-1:0]       da;
  logic [DATA_W-1:0]       db;
  logic                    da_eq_db;
  logic                    stall;
  logic                    issue;

  modport master (
    output id_valid, id_rs, id_rt,
    output id_use_rs, id_use_rt,
    output id_dest, id_we, id_load,
    output ext_stall, flush_id, flush_all,
    output qa, qb, stage_data,
    input  da, db, da_eq_db, stall, issue
  );

  modport slave (
    input  id_valid, id_rs, id_rt,
    input  id_use_rs, id_use_rt,
    input  id_dest, id_we, id_load,
    input  ext_stall, flush_id, flush_all,
    input  qa, qb, stage_data,
    output da, db, da_eq_db, stall, issue
  );

endinterface

// File: rtl/fwd_scoreboard_select.sv
// Per-operand forward select: youngest matching entry wins,
// forwards its stage result or flags a not-yet-ready load.
module fwd_select
  import fwd_scoreboard_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  entry_t [DEPTH-1:0]        tbl,
  input  logic                      en,
  input  reg_t                      rsel,
  input  logic [DEPTH*DATA_W-1:0]   stage_data,
  input  logic [DATA_W-1:0]         q,
  output logic [DATA_W-1:0]         operand,
  output logic                      hazard
);

  logic found;

  // Scan from EXE outward; the first hit masks older ones.
  always_comb begin
    operand = q;
    hazard  = 1'b0;
    found   = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && hits(tbl[k], en, rsel)) begin
        found = 1'b1;
        if (stage_t'(k) >= tbl[k].ready_at) begin
          operand = stage_data[k*DATA_W +: DATA_W];
        end else begin
          hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks pending regfile writes after ID,
// forwards ready results and stalls ID on unready loads.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LOAD_STAGE = LOAD_STAGE_DEF
) (
  input  logic            clk,
  input  logic            reset,
  fwd_scoreboard_if.slave bus
);

  if (LOAD_STAGE >= DEPTH) begin : g_bad_load
    $error("fwd_scoreboard: LOAD_STAGE must be < DEPTH");
  end
  if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("fwd_scoreboard: DEPTH out of range");
  end

  entry_t [DEPTH-1:0] tbl;
  entry_t [DEPTH-1:0] view;
  entry_t             new_e;
  logic [DATA_W-1:0]  da;
  logic [DATA_W-1:0]  db;
  logic               haz_a;
  logic               haz_b;
  logic               hazard;
  logic               kill;
  logic               issue;

  // Reset presents an empty table so the clear is visible at once.
  assign view = reset ? '0 : tbl;

  fwd_select #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_sel_a (
    .tbl        (view),
    .en         (bus.id_use_rs),
    .rsel       (bus.id_rs),
    .stage_data (bus.stage_data),
    .q          (bus.qa),
    .operand    (da),
    .hazard     (haz_a)
  );

  fwd_select #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_sel_b (
    .tbl        (view),
    .en         (bus.id_use_rt),
    .rsel       (bus.id_rt),
    .stage_data (bus.stage_data),
    .q          (bus.qb),
    .operand    (db),
    .hazard     (haz_b)
  );

  assign hazard = haz_a | haz_b;
  assign kill   = bus.flush_id | bus.flush_all;
  assign issue  = bus.id_valid & ~hazard
                & ~bus.ext_stall & ~kill;

  assign bus.da       = da;
  assign bus.db       = db;
  assign bus.da_eq_db = (da == db);
  assign bus.stall    = bus.id_valid & hazard & ~kill;
  assign bus.issue    = issue;

  always_comb begin
    new_e          = '0;
    new_e.valid    = 1'b1;
    new_e.we       = bus.id_we;
    new_e.dest     = bus.id_dest;
    new_e.ready_at = bus.id_load ? stage_t'(LOAD_STAGE) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tbl <= '0;
    end else if (bus.flush_all) begin
      for (int k = 0; k < DEPTH; k++) begin
        tbl[k].valid <= 1'b0;
      end
    end else if (!bus.ext_stall) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        tbl[k] <= tbl[k-1];
      end
      tbl[0] <= issue ? new_e : '0;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard with an in-bench model of
// in-flight writers (age-tagged queue) checked every cycle.
module tb_fwd_scoreboard;
  import fwd_scoreboard_pkg::*;

  localparam int DEPTH  = 3;
  localparam int DATA_W = 32;
  localparam int LS     = 2;
  localparam logic [31:0] QA = 32'h0000_00A0;
  localparam logic [31:0] QB = 32'h0000_00B0;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  fwd_scoreboard_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

  fwd_scoreboard #(
    .DEPTH      (DEPTH),
    .DATA_W     (DATA_W),
    .LOAD_STAGE (LS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0] dest;
    logic       we;
    logic       load;
    int         age;
  } pend_t;

  pend_t pq[$];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  name, act, exp);
  endtask

  function automatic logic [31:0] slice(int k);
    logic [DEPTH*DATA_W-1:0] s;
    s = bus.stage_data;
    return s[k*DATA_W +: DATA_W];
  endfunction

  // Youngest in-flight writer of r decides; loads are usable
  // only once they have aged LS edges.
  task automatic lookup(input logic en, input logic [4:0] r,
                        input logic [31:0] q,
                        output logic [31:0] val,
                        output logic haz);
    int best;
    best = -1;
    val  = q;
    haz  = 1'b0;
    if (!reset && en && r != 5'd0) begin
      foreach (pq[i]) begin
        if (pq[i].we && pq[i].dest == r && pq[i].age < DEPTH &&
            (best < 0 || pq[i].age < pq[best].age))
          best = i;
      end
    end
    if (best >= 0) begin
      if (pq[best].load && pq[best].age < LS) haz = 1'b1;
      else val = slice(pq[best].age);
    end
  endtask

  task automatic model(output logic [31:0] ea, output logic ha,
                       output logic [31:0] eb, output logic hb,
                       output logic es, output logic ei);
    logic h;
    lookup(bus.id_use_rs, bus.id_rs, bus.qa, ea, ha);
    lookup(bus.id_use_rt, bus.id_rt, bus.qb, eb, hb);
    h  = ha | hb;
    es = bus.id_valid & h & ~bus.flush_id & ~bus.flush_all;
    ei = bus.id_valid & ~h & ~bus.ext_stall
       & ~bus.flush_id & ~bus.flush_all;
  endtask

  always @(posedge clk) begin
    logic [31:0] ea, eb;
    logic ha, hb, es, ei;
    pend_t nq[$];
    model(ea, ha, eb, hb, es, ei);
    if (reset || bus.flush_all) begin
      pq.delete();
    end else if (!bus.ext_stall) begin
      nq.delete();
      foreach (pq[i]) begin
        if (pq[i].age + 1 < DEPTH) begin
          nq.push_back(pq[i]);
          nq[$].age = pq[i].age + 1;
        end
      end
      if (ei) nq.push_front('{bus.id_dest, bus.id_we,
                              bus.id_load, 0});
      pq = nq;
    end
  end

  always @(negedge clk) begin
    logic [31:0] ea, eb;
    logic ha, hb, es, ei;
    if (chk_en) begin
      model(ea, ha, eb, hb, es, ei);
      if (!ha) chk("m_da", bus.da, ea);
      if (!hb) chk("m_db", bus.db, eb);
      if (!ha && !hb)
        chk("m_eq", {31'd0, bus.da_eq_db}, {31'd0, ea == eb});
      chk("m_stall", {31'd0, bus.stall}, {31'd0, es});
      chk("m_issue", {31'd0, bus.issue}, {31'd0, ei});
    end
  end

  task automatic idle();
    bus.id_valid   = 1'b0;
    bus.id_rs      = '0;
    bus.id_rt      = '0;
    bus.id_use_rs  = 1'b0;
    bus.id_use_rt  = 1'b0;
    bus.id_dest    = '0;
    bus.id_we      = 1'b0;
    bus.id_load    = 1'b0;
    bus.ext_stall  = 1'b0;
    bus.flush_id   = 1'b0;
    bus.flush_all  = 1'b0;
    bus.qa         = QA;
    bus.qb         = QB;
  endtask

  task automatic wr(input logic [4:0] d, input logic ld);
    idle();
    bus.id_valid = 1'b1;
    bus.id_dest  = d;
    bus.id_we    = 1'b1;
    bus.id_load  = ld;
  endtask

  task automatic rd(input logic [4:0] a, input logic ua,
                    input logic [4:0] b, input logic ub);
    idle();
    bus.id_valid  = 1'b1;
    bus.id_rs     = a;
    bus.id_use_rs = ua;
    bus.id_rt     = b;
    bus.id_use_rt = ub;
  endtask

  task automatic stg(input logic [31:0] s0, s1, s2);
    bus.stage_data = {s2, s1, s0};
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    stg(32'h0, 32'h0, 32'h0);
    reset  = 1'b1;
    chk_en = 1'b1;
    mid();
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_issue", {31'd0, bus.issue}, 32'd0);
    chk("rst_da", bus.da, QA);
    fin();
    wr(5'd5, 1'b0);
    mid();
    chk("rst_issue_v", {31'd0, bus.issue}, 32'd1);
    fin();
    reset = 1'b0;
    mid(); fin();
    // ALU result in EXE is forwarded next cycle
    rd(5'd5, 1'b1, 5'd0, 1'b0);
    stg(32'h1234, 32'h2222, 32'h3333);
    mid();
    chk("alu_da", bus.da, 32'h1234);
    chk("alu_stall", {31'd0, bus.stall}, 32'd0);
    fin();
    wr(5'd7, 1'b1);
    stg(32'h1111_0000, 32'h2222_0000, 32'h3333_0000);
    mid(); fin();
    rd(5'd0, 1'b0, 5'd7, 1'b1);
    mid();
    chk("ld_stall1", {31'd0, bus.stall}, 32'd1);
    chk("ld_issue1", {31'd0, bus.issue}, 32'd0);
    fin();
    mid();
    chk("ld_stall2", {31'd0, bus.stall}, 32'd1);
    fin();
    mid();
    chk("ld_db", bus.db, 32'h3333_0000);
    chk("ld_issue3", {31'd0, bus.issue}, 32'd1);
    fin();
    wr(5'd3, 1'b0);
    mid(); fin();
    mid(); fin();
    rd(5'd3, 1'b1, 5'd0, 1'b0);
    stg(32'hAAAA, 32'hBBBB, 32'hCCCC);
    mid();
    chk("young_da", bus.da, 32'hAAAA);
    fin();
    mid();
    chk("young_k1", bus.da, 32'hBBBB);
    fin();
    wr(5'd0, 1'b0);
    mid(); fin();
    rd(5'd0, 1'b1, 5'd0, 1'b1);
    bus.qa = 32'h0;
    bus.qb = 32'h0;
    stg(32'hDEAD, 32'hDEAD, 32'hDEAD);
    mid();
    chk("r0_da", bus.da, 32'h0);
    chk("r0_stall", {31'd0, bus.stall}, 32'd0);
    chk("r0_eq", {31'd0, bus.da_eq_db}, 32'd1);
    fin();
    wr(5'd9, 1'b1);
    stg(32'h1, 32'h2, 32'h3);
    mid(); fin();
    idle();
    bus.id_valid  = 1'b1;
    bus.flush_all = 1'b1;
    mid();
    chk("fa_issue", {31'd0, bus.issue}, 32'd0);
    fin();
    rd(5'd9, 1'b1, 5'd0, 1'b0);
    mid();
    chk("fa_da", bus.da, QA);
    chk("fa_stall", {31'd0, bus.stall}, 32'd0);
    fin();
    wr(5'd9, 1'b1);
    mid(); fin();
    rd(5'd9, 1'b1, 5'd0, 1'b0);
    bus.ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("fz_stall", {31'd0, bus.stall}, 32'd1);
      chk("fz_issue", {31'd0, bus.issue}, 32'd0);
      fin();
    end
    bus.ext_stall = 1'b0;
    mid();
    chk("fz_held", {31'd0, bus.stall}, 32'd1);
    fin();
    mid(); fin();
    mid();
    chk("fz_da", bus.da, 32'h3);
    fin();
    wr(5'd12, 1'b1);
    mid(); fin();
    rd(5'd12, 1'b1, 5'd0, 1'b0);
    bus.flush_id = 1'b1;
    mid();
    chk("fid_stall", {31'd0, bus.stall}, 32'd0);
    chk("fid_issue", {31'd0, bus.issue}, 32'd0);
    fin();
    bus.flush_id = 1'b0;
    mid();
    chk("rs_pre", {31'd0, bus.stall}, 32'd1);
    fin();
    reset = 1'b1;
    bus.flush_all = 1'b1;
    mid();
    chk("rs_stall", {31'd0, bus.stall}, 32'd0);
    fin();
    reset = 1'b0;
    bus.flush_all = 1'b0;
    mid();
    chk("rs_after", {31'd0, bus.stall}, 32'd0);
    chk("rs_da", bus.da, QA);
    fin();
    idle();
    mid(); fin();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
